char_plot_scheduler: RTL

CHAR_PLOT_SCHEDULER -- requirements
Module: char_plot_scheduler

---
 rtl/notepad_pkg.sv | 46 ++++
 rtl/cursor_tracker.sv | 76 +++++++
 rtl/char_plot_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/notepad_pkg.sv
// Shared constants, state encoding and cursor operations for the text-plot scheduler.
// Grid geometry, glyph cell size and control codes live here so all files agree.
package notepad_pkg;

  localparam int COLS_DEFAULT = 20;
  localparam int ROWS_DEFAULT = 7;
  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int GLYPH_W_LOG2 = $clog2(GLYPH_W);
  localparam int GLYPH_H_LOG2 = $clog2(GLYPH_H);

  localparam int COL_W  = 5;
  localparam int ROW_W  = 3;
  localparam int CODE_W = 7;
  localparam int X_W    = 9;
  localparam int Y_W    = 10;

  localparam logic [CODE_W-1:0] CODE_BS = 7'h08;
  localparam logic [CODE_W-1:0] CODE_LF = 7'h0A;
  localparam logic [CODE_W-1:0] CODE_FF = 7'h0C;
  localparam logic [CODE_W-1:0] CODE_CR = 7'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_ADVANCE,
    S_CLEAR_ISSUE,
    S_CLEAR_WAIT
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_ADVANCE,
    OP_NEWLINE,
    OP_BACK,
    OP_HOME,
    OP_CLEAR_STEP
  } cursor_op_e;

  function automatic logic is_printable(input logic [CODE_W-1:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/cursor_tracker.sv
// Owns the text cursor (col,row) and applies one cursor operation per cycle.
// Rows wrap bottom -> top; there is no scrolling.
import notepad_pkg::*;

module cursor_tracker #(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  cursor_op_e       op,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_cell
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [ROW_W-1:0] row_wrapped;

  assign row_wrapped = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    case (op)
      OP_ADVANCE, OP_CLEAR_STEP: begin
        if (col_reg == COL_LAST) begin
          col_next = '0;
          row_next = row_wrapped;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end
      OP_NEWLINE: begin
        col_next = '0;
        row_next = row_wrapped;
      end
      OP_BACK: begin
        // At the home cell backspace has nowhere to go and stays put.
        if (col_reg != '0) begin
          col_next = col_reg - 1'b1;
        end else if (row_reg != '0) begin
          col_next = COL_LAST;
          row_next = row_reg - 1'b1;
        end
      end
      OP_HOME: begin
        col_next = '0;
        row_next = '0;
      end
      default: begin
        col_next = col_reg;
        row_next = row_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  assign col       = col_reg;
  assign row       = row_reg;
  assign last_cell = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

endmodule

// File: rtl/char_plot_scheduler.sv
// Accepts character codes and schedules glyph renders on a COLS x ROWS text grid,
// handling printable, newline, backspace and full-screen clear.
import notepad_pkg::*;

module char_plot_scheduler #(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              char_valid,
  input  logic [CODE_W-1:0] char_code,
  output logic              char_ready,
  output logic              glyph_start,
  output logic [X_W-1:0]    glyph_x,
  output logic [Y_W-1:0]    glyph_y,
  output logic [CODE_W-1:0] glyph_code,
  output logic              glyph_erase,
  input  logic              glyph_done,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  state_e            state_reg, state_next;
  cursor_op_e        cursor_op;
  logic              last_cell;
  logic              ready_en_reg;
  logic [CODE_W-1:0] code_reg;
  logic              glyph_start_reg;
  logic [X_W-1:0]    glyph_x_reg;
  logic [Y_W-1:0]    glyph_y_reg;
  logic [CODE_W-1:0] glyph_code_reg;
  logic              glyph_erase_reg;
  logic              is_newline;
  logic              is_issue;

  cursor_tracker #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (cursor_op),
    .col       (cursor_col),
    .row       (cursor_row),
    .last_cell (last_cell)
  );

  assign is_newline = (code_reg == CODE_LF) || (code_reg == CODE_CR);
  assign is_issue   = (state_reg == S_ISSUE) || (state_reg == S_CLEAR_ISSUE);

  // Ready is held off until the first edge after reset so nothing is accepted in reset.
  assign char_ready = (state_reg == S_IDLE) && ready_en_reg;
  assign busy       = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      ready_en_reg <= 1'b0;
      code_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (char_valid && char_ready) begin
        code_reg <= char_code;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cursor_op  = OP_NONE;
    case (state_reg)
      S_IDLE: begin
        if (char_valid && char_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_printable(code_reg)) begin
          state_next = S_ISSUE;
        end else if (is_newline) begin
          state_next = S_ADVANCE;
        end else if (code_reg == CODE_BS) begin
          cursor_op  = OP_BACK;
          state_next = S_ISSUE;
        end else if (code_reg == CODE_FF) begin
          cursor_op  = OP_HOME;
          state_next = S_CLEAR_ISSUE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A backspace erase leaves the cursor on the erased cell.
        if (glyph_done) state_next = (code_reg == CODE_BS) ? S_IDLE : S_ADVANCE;
      end
      S_ADVANCE: begin
        cursor_op  = is_newline ? OP_NEWLINE : OP_ADVANCE;
        state_next = S_IDLE;
      end
      S_CLEAR_ISSUE: state_next = S_CLEAR_WAIT;
      S_CLEAR_WAIT: begin
        if (glyph_done) begin
          if (last_cell) begin
            cursor_op  = OP_HOME;
            state_next = S_IDLE;
          end else begin
            cursor_op  = OP_CLEAR_STEP;
            state_next = S_CLEAR_ISSUE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Render attributes are captured once per cell and held until the next issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glyph_start_reg <= 1'b0;
      glyph_x_reg     <= '0;
      glyph_y_reg     <= '0;
      glyph_code_reg  <= '0;
      glyph_erase_reg <= 1'b0;
    end else begin
      glyph_start_reg <= is_issue;
      if (is_issue) begin
        glyph_x_reg     <= X_W'(cursor_col) << GLYPH_W_LOG2;
        glyph_y_reg     <= Y_W'(cursor_row) << GLYPH_H_LOG2;
        glyph_code_reg  <= code_reg;
        glyph_erase_reg <= (state_reg == S_CLEAR_ISSUE) || (code_reg == CODE_BS);
      end
    end
  end

  assign glyph_start = glyph_start_reg;
  assign glyph_x     = glyph_x_reg;
  assign glyph_y     = glyph_y_reg;
  assign glyph_code  = glyph_code_reg;
  assign glyph_erase = glyph_erase_reg;

endmodule
